apb_cmd_master: RTL and testbench

- Upstream APB requester: turns a single-entry valid/ready command into one APB3 transfer, then returns the result on a valid/ready response channel.
- Sits between a CPU-side or bench-side command source and any 4KB APB slave, including the GPP register bank.
- Has one transfer in flight at a time.
- Adds address-alignment checking and a PREADY timeout, so a stuck slave cannot hang the requester.

---
 rtl/apb_cmd_master.sv | 137 +++++++++++++
 tb/tb_apb_cmd_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 requester: accepts one valid/ready command, runs a single APB transfer
// (with alignment check and PREADY timeout), and returns a valid/ready response.
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam int                   TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TO_LAST_I);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                      r_state;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [APB_ADDR_WIDTH-1:0]   r_paddr;
    logic [31:0]                 r_pwdata;
    logic                        r_pwrite;
    logic [31:0]                 r_rsp_rdata;
    logic                        r_rsp_err;
    logic                        r_rsp_to;

    state_t                      w_state_nxt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic [31:0]                 w_rsp_rdata_nxt;
    logic                        w_rsp_err_nxt;
    logic                        w_rsp_to_nxt;
    logic                        w_capture;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
            if (w_capture) begin
                r_pwrite <= req_write;
                r_paddr  <= req_addr;
                r_pwdata <= req_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_to_nxt    = r_rsp_to;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with an error without touching the bus
                        w_state_nxt     = S_RESP;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_to_nxt    = 1'b0;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_rdata_nxt = (!r_pwrite && !PSLVERR) ? PRDATA : 32'h0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_to_nxt    = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // All handshake and bus-control outputs are pure decodes of the state register
    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign PENABLE     = (r_state == S_ACCESS);
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: vector table driven through a bench-side APB slave,
// with a response scoreboard plus backpressure and mid-transfer reset sequences.
module tb_apb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    apb_cmd_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          waits;     // PREADY-low ACCESS cycles; -1 = slave never ready
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_access;
        bit          exp_apb;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    int   last_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic [11:0] addr,
                                input logic [31:0] wdata, input int waits, input logic slverr,
                                input logic [31:0] prdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input logic exp_to, input int exp_access,
                                input bit exp_apb);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
        v.slverr = slverr; v.prdata = prdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_to = exp_to; v.exp_access = exp_access; v.exp_apb = exp_apb;
        return v;
    endfunction

    // Issues the command, plays the slave, and returns while the response is visible.
    task automatic run_vec(input vec_t v);
        int   k;
        int   nsetup;
        int   nacc;
        bit   seen;
        int   exp_lat;
        exp_t e;
        chk({v.name, "/req_ready_idle"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, to: v.exp_to});
        @(posedge HCLK); #1;
        prev_acc = last_acc;
        last_acc = cyc;
        req_valid = 1'b0;
        k = 0; nsetup = 0; nacc = 0; seen = 1'b0;
        while (k < 60) begin
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (PSEL && !PENABLE) begin
                nsetup++;
                chk({v.name, "/setup_paddr"}, 32'(PADDR), 32'(v.addr));
                chk({v.name, "/setup_pwrite"}, 32'(PWRITE), 32'(v.wr));
                if (v.wr) chk({v.name, "/setup_pwdata"}, PWDATA, v.wdata);
            end else if (PSEL && PENABLE) begin
                nacc++;
                chk({v.name, "/access_paddr"}, 32'(PADDR), 32'(v.addr));
                PRDATA = v.prdata;
                if (v.waits >= 0 && nacc - 1 == v.waits) begin
                    PREADY  = 1'b1;
                    PSLVERR = v.slverr;
                end
            end else if (PENABLE) begin
                chk({v.name, "/penable_without_psel"}, 32'(PENABLE), 32'h0);
            end
            @(posedge HCLK); #1;
            k++;
        end
        exp_lat  = v.exp_apb ? 1 + v.exp_access : 0;
        last_lat = k;
        chk({v.name, "/rsp_seen"}, 32'(seen), 32'h1);
        chk({v.name, "/latency"}, 32'(k), 32'(exp_lat));
        chk({v.name, "/setup_cycles"}, 32'(nsetup), v.exp_apb ? 32'h1 : 32'h0);
        chk({v.name, "/access_cycles"}, 32'(nacc), 32'(v.exp_access));
        if (seen) begin
            if (sb.size() == 0) begin
                chk({v.name, "/sb_nonempty"}, 32'h0, 32'h1);
            end else begin
                e = sb.pop_front();
                chk({v.name, "/rsp_rdata"}, rsp_rdata, e.rdata);
                chk({v.name, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
                chk({v.name, "/rsp_timeout"}, 32'(rsp_timeout), 32'(e.to));
                chk({v.name, "/req_ready_busy"}, 32'(req_ready), 32'h0);
                chk({v.name, "/psel_in_resp"}, 32'(PSEL), 32'h0);
            end
        end
    endtask

    task automatic post_rsp(input string name);
        @(posedge HCLK); #1;
        chk({name, "/rsp_valid_cleared"}, 32'(rsp_valid), 32'h0);
        chk({name, "/req_ready_back"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_rsp;
        vecs[0] = mk("wr_aligned",  1'b1, 12'h010, 32'hDEADBEEF,  0, 1'b0, 32'h12345678, 32'h0,        1'b0, 1'b0,  1, 1'b1);
        vecs[1] = mk("rd_back",     1'b0, 12'h010, 32'h0,         0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0,  1, 1'b1);
        vecs[2] = mk("rd_waits5",   1'b0, 12'h020, 32'h0,         5, 1'b0, 32'h0A5A5A5A, 32'h0A5A5A5A, 1'b0, 1'b0,  6, 1'b1);
        vecs[3] = mk("rd_timeout",  1'b0, 12'h030, 32'h0,        -1, 1'b0, 32'h77777777, 32'h0,        1'b1, 1'b1, 16, 1'b1);
        vecs[4] = mk("wr_misalign", 1'b1, 12'h013, 32'h11111111,  0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0,  0, 1'b0);
        vecs[5] = mk("rd_slverr",   1'b0, 12'h040, 32'h0,         0, 1'b1, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0,  1, 1'b1);
        vecs[6] = mk("wr_slverr_w2",1'b1, 12'h044, 32'h89ABCDEF,  2, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0,  3, 1'b1);
        vecs[7] = mk("rd_misalign", 1'b0, 12'h002, 32'h0,         0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0,  0, 1'b0);
        vecs[8] = mk("rd_top_w1",   1'b0, 12'hFFC, 32'h0,         1, 1'b0, 32'h5555AAAA, 32'h5555AAAA, 1'b0, 1'b0,  2, 1'b1);

        HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset/req_ready", 32'(req_ready), 32'h1);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset/rsp_rdata", rsp_rdata, 32'h0);
        chk("reset/rsp_err", 32'(rsp_err), 32'h0);
        chk("reset/rsp_timeout", 32'(rsp_timeout), 32'h0);
        chk("reset/psel", 32'(PSEL), 32'h0);
        chk("reset/penable", 32'(PENABLE), 32'h0);
        chk("reset/pwrite", 32'(PWRITE), 32'h0);
        chk("reset/paddr", 32'(PADDR), 32'h0);
        chk("reset/pwdata", PWDATA, 32'h0);
        HRESET = 1'b0;

        // Back-to-back table run: accept-to-accept spacing is response latency + 2
        for (int i = 0; i < 9; i++) begin
            int exp_gap;
            exp_gap = last_lat + 2;
            run_vec(vecs[i]);
            if (i > 0) chk({vecs[i].name, "/accept_spacing"}, 32'(last_acc - prev_acc), 32'(exp_gap));
            post_rsp(vecs[i].name);
        end

        // Backpressure: response must hold for 10 cycles; a new request is ignored
        rsp_ready = 1'b0;
        run_vec(mk("rd_bp", 1'b0, 12'h060, 32'h0, 0, 1'b0, 32'h13579BDF, 32'h13579BDF, 1'b0, 1'b0, 1, 1'b1));
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h070; req_wdata = 32'hA5A5A5A5;
        for (int j = 0; j < 10; j++) begin
            @(posedge HCLK); #1;
            chk("bp/rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp/rsp_rdata", rsp_rdata, 32'h13579BDF);
            chk("bp/rsp_err", 32'(rsp_err), 32'h0);
            chk("bp/req_ready", 32'(req_ready), 32'h0);
            chk("bp/psel", 32'(PSEL), 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        post_rsp("bp");

        // Reset during ACCESS aborts with no response
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h050; req_wdata = 32'h0;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        @(posedge HCLK); #1;
        chk("rst_mid/in_access", 32'(PENABLE), 32'h1);
        @(posedge HCLK); #1;
        chk("rst_mid/still_access", 32'(PSEL & PENABLE), 32'h1);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk("rst_mid/psel", 32'(PSEL), 32'h0);
        chk("rst_mid/penable", 32'(PENABLE), 32'h0);
        chk("rst_mid/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mid/req_ready", 32'(req_ready), 32'h1);
        saw_rsp = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge HCLK); #1;
            if (rsp_valid || PSEL) saw_rsp = 1'b1;
        end
        chk("rst_mid/no_activity", 32'(saw_rsp), 32'h0);

        // Timeout again after reset: the counter must have restarted from zero
        run_vec(vecs[3]);
        post_rsp("timeout_after_rst");

        chk("sb/empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
